// File: rtl/mips_fetch_pkg.sv
// Shared fetch-side types: word address, fetch FSM states and the boot PC.
package mips_fetch_pkg;

  typedef logic [29:0] word_addr_t;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  localparam word_addr_t RESET_PC_DEFAULT = 30'h0010_0000;

endpackage

// File: rtl/mips_fetch_pc_gen_if.sv
// Fetch PC generator bus: predictor/EX inputs towards the generator, PC and flush back out.
interface mips_fetch_pc_gen_if #(
  parameter int CNT_W = 16
);
  import mips_fetch_pkg::*;

  logic              stall;
  logic              br_pred_taken;
  word_addr_t        branch_prediction_addr;
  logic              ex_resolve_valid;
  word_addr_t        ex_next_pc;
  word_addr_t        inst_addr_PC;
  logic              pc_valid;
  logic              flush;
  logic              mispredict;
  logic [CNT_W-1:0]  mispredict_count;

  modport master (
    output stall, br_pred_taken, branch_prediction_addr, ex_resolve_valid, ex_next_pc,
    input  inst_addr_PC, pc_valid, flush, mispredict, mispredict_count
  );

  modport slave (
    input  stall, br_pred_taken, branch_prediction_addr, ex_resolve_valid, ex_next_pc,
    output inst_addr_PC, pc_valid, flush, mispredict, mispredict_count
  );

endinterface

// File: rtl/mips_fetch_track.sv
// Two-stage IF->ID->EX shift register of valid bit and predicted next PC.
// Holds on stall; a flush turns the instructions entering ID and EX into bubbles.
module mips_fetch_track
  import mips_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_b,
  input  logic       i_stall,
  input  logic       i_flush,
  input  logic       i_valid_if,
  input  word_addr_t i_pnext_if,
  output logic       o_valid_ex,
  output word_addr_t o_pnext_ex
);

  logic       r_valid_id;
  word_addr_t r_pnext_id;
  logic       r_valid_ex;
  word_addr_t r_pnext_ex;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_valid_id <= 1'b0;
      r_pnext_id <= '0;
      r_valid_ex <= 1'b0;
      r_pnext_ex <= '0;
    end else if (!i_stall) begin
      r_valid_id <= i_valid_if & ~i_flush;
      r_pnext_id <= i_pnext_if;
      r_valid_ex <= r_valid_id & ~i_flush;
      r_pnext_ex <= r_pnext_id;
    end
  end

  assign o_valid_ex = r_valid_ex;
  assign o_pnext_ex = r_pnext_ex;

endmodule

// File: rtl/mips_fetch_pc_gen.sv
// Fetch next-PC generator: EX redirect > predicted-taken target > PC+1, one register stage.
// Mispredicts are detected against the tracked prediction in EX; stall freezes all state.
module mips_fetch_pc_gen
  import mips_fetch_pkg::*;
#(
  parameter word_addr_t RESET_PC = RESET_PC_DEFAULT,
  parameter int         CNT_W    = 16
) (
  input  logic clk,
  input  logic rst_b,
  mips_fetch_pc_gen_if.slave bus
);

  fetch_state_t     r_state;
  fetch_state_t     w_state_nxt;
  word_addr_t       r_pc;
  word_addr_t       w_pc_nxt;
  word_addr_t       w_pnext_if;
  logic [CNT_W-1:0] r_cnt;
  logic             w_pc_valid;
  logic             w_mispredict;
  logic             w_valid_ex;
  word_addr_t       w_pnext_ex;

  assign w_pc_valid = (r_state == RUN);
  assign w_pnext_if = bus.br_pred_taken ? bus.branch_prediction_addr : r_pc + 30'd1;

  // Flush bubbles have valid_ex=0, so they can never raise a redirect.
  assign w_mispredict = ~bus.stall & w_valid_ex & bus.ex_resolve_valid
                        & (bus.ex_next_pc != w_pnext_ex);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    if (!bus.stall) begin
      unique case (r_state)
        BOOT: w_state_nxt = RUN;
        RUN:  w_pc_nxt    = w_mispredict ? bus.ex_next_pc : w_pnext_if;
        default: w_state_nxt = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt <= '0;
    end else if (w_mispredict && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  mips_fetch_track u_track (
    .clk        (clk),
    .rst_b      (rst_b),
    .i_stall    (bus.stall),
    .i_flush    (w_mispredict),
    .i_valid_if (w_pc_valid),
    .i_pnext_if (w_pnext_if),
    .o_valid_ex (w_valid_ex),
    .o_pnext_ex (w_pnext_ex)
  );

  assign bus.inst_addr_PC     = r_pc;
  assign bus.pc_valid         = w_pc_valid;
  assign bus.flush            = w_mispredict;
  assign bus.mispredict       = w_mispredict;
  assign bus.mispredict_count = r_cnt;

endmodule

// File: tb/tb_mips_fetch_pc_gen.sv
// Directed bench for mips_fetch_pc_gen: stimulus queues expected outputs, a negedge monitor checks them.
module tb_mips_fetch_pc_gen;
  import mips_fetch_pkg::*;

  // Narrow counter so saturation is reachable in a few hundred cycles.
  localparam int CW = 6;
  localparam word_addr_t R = 30'h0010_0000;
  localparam word_addr_t T = 30'h0000_2000;

  logic clk;
  logic rst_b;

  mips_fetch_pc_gen_if #(.CNT_W(CW)) bus ();

  mips_fetch_pc_gen #(.RESET_PC(R), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  typedef struct {
    string           nm;
    word_addr_t      pc;
    logic            pv;
    logic            fl;
    logic [CW-1:0]   cnt;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic stim_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CW-1:0] sat(input int v);
    return (v > (1 << CW) - 1) ? {CW{1'b1}} : v[CW-1:0];
  endfunction

  task automatic step(input logic rb, input logic st, input logic bpt, input word_addr_t bpa,
                      input logic erv, input word_addr_t enp,
                      input word_addr_t e_pc, input logic e_pv, input logic e_fl,
                      input logic [CW-1:0] e_cnt, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_b                      = rb;
    bus.stall                  = st;
    bus.br_pred_taken          = bpt;
    bus.branch_prediction_addr = bpa;
    bus.ex_resolve_valid       = erv;
    bus.ex_next_pc             = enp;
    e.nm = nm; e.pc = e_pc; e.pv = e_pv; e.fl = e_fl; e.cnt = e_cnt;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_tests++;
        if (bus.inst_addr_PC !== e.pc || bus.pc_valid !== e.pv || bus.flush !== e.fl ||
            bus.mispredict !== e.fl || bus.mispredict_count !== e.cnt) begin
          n_fail++;
          $display("FAIL %s: got pc=%h pv=%b fl=%b mp=%b cnt=%0d, want pc=%h pv=%b fl=%b cnt=%0d",
                   e.nm, bus.inst_addr_PC, bus.pc_valid, bus.flush, bus.mispredict,
                   bus.mispredict_count, e.pc, e.pv, e.fl, e.cnt);
        end
      end
    end
  end

  initial begin : stim
    rst_b = 1'b0;
    bus.stall = 1'b0; bus.br_pred_taken = 1'b0; bus.branch_prediction_addr = '0;
    bus.ex_resolve_valid = 1'b0; bus.ex_next_pc = '0;

    step(0, 0, 0, '0, 0, '0, R,        0, 0, 0, "reset");
    step(1, 0, 0, '0, 0, '0, R,        0, 0, 0, "boot");
    step(1, 0, 0, '0, 0, '0, R,        1, 0, 0, "seq0");
    step(1, 0, 0, '0, 0, '0, R + 1,    1, 0, 0, "seq1");
    step(1, 0, 0, '0, 0, '0, R + 2,    1, 0, 0, "seq2");
    step(1, 0, 1, 30'h100040, 0, '0, 30'h100003, 1, 0, 0, "pred_taken");
    step(1, 0, 0, '0, 0, '0, 30'h100040, 1, 0, 0, "pred_target");
    step(1, 0, 0, '0, 1, 30'h100040, 30'h100041, 1, 0, 0, "pred_resolve_ok");
    step(1, 0, 0, '0, 0, '0, 30'h100042, 1, 0, 0, "seq3");
    step(1, 0, 0, '0, 1, 30'h100080, 30'h100043, 1, 1, 0, "mp_detect");
    step(1, 0, 0, '0, 1, 30'h000123, 30'h100080, 1, 0, 1, "mp_redirect_bubble0");
    step(1, 0, 0, '0, 1, 30'h000123, 30'h100081, 1, 0, 1, "mp_bubble1");
    step(1, 1, 0, '0, 1, 30'h100200, 30'h100082, 1, 0, 1, "stall0");
    step(1, 1, 0, '0, 1, 30'h100200, 30'h100082, 1, 0, 1, "stall1");
    step(1, 1, 0, '0, 1, 30'h100200, 30'h100082, 1, 0, 1, "stall2");
    step(1, 0, 1, 30'h100300, 1, 30'h100200, 30'h100082, 1, 1, 1, "stall_release_flush");
    step(1, 0, 0, '0, 0, '0, 30'h100200, 1, 0, 2, "redirect_beats_pred");
    step(1, 0, 0, '0, 0, '0, 30'h100201, 1, 0, 2, "seq4");
    step(1, 0, 1, 30'h3FFFFFFF, 0, '0, 30'h100202, 1, 0, 2, "pred_to_top");
    step(1, 0, 0, '0, 0, '0, 30'h3FFFFFFF, 1, 0, 2, "pc_top");
    step(1, 0, 0, '0, 0, '0, 30'h0, 1, 0, 2, "pc_wrap");

    for (int k = 0; k < 66; k++) begin
      step(1, 0, 0, '0, 1, T, (k == 0) ? 30'h1 : T + 2, 1, 1, sat(k + 2), "sat_mp");
      step(1, 0, 0, '0, 1, 30'h5, T, 1, 0, sat(k + 3), "sat_bubble0");
      step(1, 0, 0, '0, 0, '0, T + 1, 1, 0, sat(k + 3), "sat_bubble1");
    end

    step(0, 0, 0, '0, 1, 30'h777, R, 0, 0, 0, "async_reset");
    step(1, 0, 0, '0, 1, 30'h777, R, 0, 0, 0, "reset_boot");
    step(1, 0, 0, '0, 1, 30'h777, R, 1, 0, 0, "reset_no_flush0");
    step(1, 0, 0, '0, 1, 30'h777, R + 1, 1, 0, 0, "reset_no_flush1");
    step(1, 0, 0, '0, 0, '0, R + 2, 1, 0, 0, "reset_seq");

    repeat (3) @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", q.size());
    end
    stim_done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    if (!stim_done) begin
      $display("FAIL watchdog: bench did not finish, %0d entries pending", q.size());
      $fatal(1, "timeout");
    end
  end

endmodule

// File: doc/mips_fetch_pc_gen.md
# mips_fetch_pc_gen

Fetch-stage next-PC generator, directly upstream of the branch predictor. Owns the architectural fetch PC (`inst_addr_PC`) that drives instruction cache and predictor. Selects the next PC from three sources: EX-stage redirect, predicted-taken target, or sequential. It carries each fetched instruction's predicted next PC through ID and EX, detects mispredictions at resolution, and issues flushes.

## Interface
Parameters:
- `RESET_PC`, default 30'h0010_0000: word address loaded on reset (byte 0x0040_0000).
- `CNT_W`, default 16: width of the mispredict counter.

Ports:
- `clk`  in  1  Clock; all state updates on the rising edge.
- `rst_b`  in  1  Asynchronous, active-low reset.
- `stall`  in  1  Pipeline hold; freezes PC, tracking registers and FSM.
- `br_pred_taken`  in  1  Predictor says the instruction at the current PC is taken with a BTB hit.
- `branch_prediction_addr`  in  30  Predicted target word address; valid when `br_pred_taken`=1.
- `ex_resolve_valid`  in  1  The instruction in EX is a branch or jump being resolved this cycle.
- `ex_next_pc`  in  30  Correct next word address for the EX instruction: the taken target or fall-through.
- `inst_addr_PC`  out  30  Current fetch word address; this is a register.
- `pc_valid`  out  1  The fetch at `inst_addr_PC` is a real instruction.
- `flush`  out  1  Combinational. Kills the IF and ID instructions this cycle.
- `mispredict`  out  1  Combinational. Single-cycle mispredict indication; equals `flush`.
- `mispredict_count`  out  CNT_W  Saturating count of mispredicts.

## Operation
- FSM states are BOOT and RUN. Reset enters BOOT.
- BOOT: `pc_valid`=0 and the PC holds `RESET_PC`. On the first non-stalled edge the FSM moves to RUN with the PC still at `RESET_PC`. No increment happens in BOOT.
- RUN: `pc_valid`=1.
- Tracking registers are `valid_ID`, `pnext_ID[29:0]`, `valid_EX` and `pnext_EX[29:0]`.
- Predicted next PC for the IF instruction: `pnext_IF` = `br_pred_taken` ? `branch_prediction_addr` : `inst_addr_PC`+1.
- `mispredict` = `!stall` & `valid_EX` & `ex_resolve_valid` & (`ex_next_pc` != `pnext_EX`).
- Next PC on a non-stalled edge in RUN, first match wins:
  1. If `mispredict`, load `ex_next_pc`.
  2. Else load `pnext_IF`.
- Tracking update on a non-stalled edge:
  - `valid_ID` <= `pc_valid` & !`flush`; `pnext_ID` <= `pnext_IF`.
  - `valid_EX` <= `valid_ID` & !`flush`; `pnext_EX` <= `pnext_ID`.
- `mispredict_count` increments on each `mispredict` and saturates at all-ones.
- PC+1 wraps modulo 2^30 with no carry out.
- Stall:
  - All registers hold and `ex_resolve_valid` is ignored.
  - `mispredict` and `flush` are forced to 0.
  - The redirect takes effect on the first cycle `stall` falls, if EX is still resolving.
- Mispredict and `br_pred_taken` in the same cycle: the redirect wins. The prediction is discarded because its instruction is flushed.
- A mispredict while `valid_EX`=0 is impossible by construction. EX bubbles created by a flush never trigger a redirect.
- Asynchronous reset mid-operation:
  - PC=`RESET_PC`, FSM=BOOT.
  - `valid_ID`=`valid_EX`=0, `pnext_*`=0, counter=0.

## Timing
- Reset values: `inst_addr_PC`=`RESET_PC`, `pc_valid`=0, `flush`=0, `mispredict`=0, `mispredict_count`=0.
- Sequential fetch has zero added latency: the new PC is visible the cycle after the edge.
- Predicted-taken redirect takes 1 cycle. `branch_prediction_addr`, sampled in cycle N, appears on `inst_addr_PC` in cycle N+1 with no bubble.
- Mispredict penalty is 2 cycles:
  - Detection in cycle N in EX; `flush` is high in N.
  - `ex_next_pc` appears on `inst_addr_PC` in N+1.
  - The IF and ID slots from cycle N become bubbles.
- The input-to-PC path (`br_pred_taken`/`branch_prediction_addr` to PC D input) is combinational and must close in one cycle together with predictor lookup.

## Structure
- Shared package `mips_fetch_pkg` holds:
  - The FSM enum `fetch_state_t` {BOOT, RUN}.
  - `RESET_PC_DEFAULT`.
  - The 30-bit `word_addr_t` typedef, reused by the predictor and BTB.
- One natural sub-module is `mips_fetch_track`: the two-stage valid/`pnext` shift register with stall and flush. It is instantiated once.
- The saturating counter stays inline.

## Test plan
- Reset release, no branches, stall=0:
  - `pc_valid`=0 for 1 cycle at 0x100000.
  - Then 0x100000, 0x100001, 0x100002, and so on.
- `br_pred_taken`=1 with target 0x100040 at PC 0x100003 -> next PC 0x100040, `flush`=0. Resolving 2 cycles later with `ex_next_pc`=0x100040 -> no mispredict.
- Predicted not-taken at 0x100005, resolved with `ex_next_pc`=0x100080:
  - `flush`=`mispredict`=1 for exactly 1 cycle.
  - PC=0x100080 next cycle, `mispredict_count`=1.
  - Next 2 EX cycles have `valid_EX`=0 despite `ex_resolve_valid`=1.
- Mispredict condition held with `stall`=1 for 3 cycles:
  - PC frozen, `flush`=0 throughout.
  - On stall release, `flush` goes to 1 and the redirect happens.
- Simultaneous mispredict (target 0x100200) and `br_pred_taken` (target 0x100300) -> PC=0x100200.
- PC 0x3FFFFFFF sequential -> wraps to 0x0.
- Force 2^16+3 mispredicts -> `mispredict_count` saturates at 0xFFFF.
- `rst_b` pulsed low mid-run with `valid_EX`=1:
  - All outputs return to reset values immediately.
  - No flush follows release.
